// File: rtl/dec_syndrome_seq.sv
// dec_syndrome_seq: time-multiplexed GF(2) syndrome computation (H x codeword)
// with error classification and single-error location. One codeword per
// valid/ready transaction; CHUNK_WIDTH codeword bits are folded in per cycle.
module dec_syndrome_seq #(
    parameter int unsigned  MAX_CODEWORD_WIDTH = 32,
    parameter int unsigned  MAX_INFO_WIDTH     = 26,
    parameter int unsigned  AMBA_WORD          = 32,
    parameter int unsigned  CHUNK_WIDTH        = 8,
    parameter logic [31:0]  H_MODE0            = 32'hFFE4_D2B1,
    parameter logic [79:0]  H_MODE1            = 80'hFFFF_FE08_F1C4_CDA2_AB61,
    parameter logic [191:0] H_MODE2            = 192'hFFFF_FFFF_FFFE_0010_FF01_FC08_F0F1_E384_CCCD_9B42_AAAB_56C1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0]              data_in,
    input  logic [AMBA_WORD-1:0]                       work_mod,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [MAX_CODEWORD_WIDTH-MAX_INFO_WIDTH-1:0] syndrome,
    output logic [1:0]                                 status,
    output logic [4:0]                                 err_pos
);

    localparam int unsigned MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
    localparam int unsigned CW_W             = 32;
    localparam int unsigned SYN_W            = 6;
    localparam int unsigned CNT_W            = 6;
    localparam int unsigned POS_W            = 5;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_SINGLE  = 2'b01;
    localparam logic [1:0] ST_DOUBLE  = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Codeword width of a mode.
    function automatic int unsigned mode_cw(input logic [1:0] m);
        int unsigned w;
        case (m)
            2'd0:    w = 8;
            2'd1:    w = 16;
            default: w = 32;
        endcase
        return w;
    endfunction

    // Mask keeping only the codeword bits that belong to a mode.
    function automatic logic [CW_W-1:0] cw_mask(input logic [1:0] m);
        logic [CW_W-1:0] mk;
        case (m)
            2'd0:    mk = 32'h0000_00FF;
            2'd1:    mk = 32'h0000_FFFF;
            default: mk = 32'hFFFF_FFFF;
        endcase
        return mk;
    endfunction

    // H row that drives syndrome bit r (row 0 = last row of the matrix).
    function automatic logic [CW_W-1:0] h_row(input logic [1:0] m, input int unsigned r);
        logic [CW_W-1:0] row;
        row = '0;
        case (m)
            2'd0: if (r < 4) row = 32'(H_MODE0 >> (r * 8)) & 32'h0000_00FF;
            2'd1: if (r < 5) row = 32'(H_MODE1 >> (r * 16)) & 32'h0000_FFFF;
            2'd2: if (r < 6) row = 32'(H_MODE2 >> (r * 32));
            default: row = '0;
        endcase
        return row;
    endfunction

    // Column c of H for a mode, arranged like the syndrome (bit r from row r).
    function automatic logic [SYN_W-1:0] h_col(input logic [1:0] m, input int unsigned c);
        logic [SYN_W-1:0] col;
        logic [CW_W-1:0]  row;
        col = '0;
        for (int unsigned r = 0; r < SYN_W; r++) begin
            row    = h_row(m, r);
            col[r] = row[c];
        end
        return col;
    endfunction

    state_t                       state_q, state_d;
    logic [CW_W-1:0]              cw_q, cw_d;
    logic [1:0]                   mode_q, mode_d;
    logic [SYN_W-1:0]             acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
    logic [MAX_PARITY_WIDTH-1:0]  syndrome_q, syndrome_d;
    logic [1:0]                   status_q, status_d;
    logic [POS_W-1:0]             err_pos_q, err_pos_d;

    logic [SYN_W-1:0]             acc_nxt;
    logic [5:0]                   shamt;
    logic [CHUNK_WIDTH-1:0]       cw_slice;
    logic [CNT_W-1:0]             last_cnt;
    logic                         mode_legal;
    logic                         syn_msb;
    logic                         col_found;
    logic [POS_W-1:0]             col_pos;
    logic [1:0]                   cls_status;
    logic [POS_W-1:0]             cls_pos;

    // Fold the current slice's contribution into the running syndrome.
    always_comb begin
        shamt    = 6'(32'(cnt_q) * CHUNK_WIDTH);
        cw_slice = CHUNK_WIDTH'(cw_q >> shamt);
        last_cnt = CNT_W'(mode_cw(mode_q) / CHUNK_WIDTH - 1);
        acc_nxt  = acc_q;
        for (int unsigned r = 0; r < SYN_W; r++) begin
            acc_nxt[r] = acc_q[r] ^ (^(CHUNK_WIDTH'(h_row(mode_q, r) >> shamt) & cw_slice));
        end
    end

    // Classify the completed syndrome and locate a single-bit error (lowest column wins).
    always_comb begin
        case (mode_q)
            2'd0:    syn_msb = acc_nxt[3];
            2'd1:    syn_msb = acc_nxt[4];
            default: syn_msb = acc_nxt[5];
        endcase
        col_found = 1'b0;
        col_pos   = '0;
        for (int unsigned c = 0; c < CW_W; c++) begin
            if (!col_found && (c < mode_cw(mode_q)) && (h_col(mode_q, c) == acc_nxt)) begin
                col_found = 1'b1;
                col_pos   = POS_W'(c);
            end
        end
        if (acc_nxt == '0) begin
            cls_status = ST_NONE;
            cls_pos    = '0;
        end else if (syn_msb && col_found) begin
            cls_status = ST_SINGLE;
            cls_pos    = col_pos;
        end else begin
            cls_status = ST_DOUBLE;
            cls_pos    = '0;
        end
    end

    // Mode legality of the request presented at the input.
    always_comb begin
        mode_legal = (work_mod < AMBA_WORD'(3)) &&
                     (mode_cw(work_mod[1:0]) <= MAX_CODEWORD_WIDTH);
    end

    // Next-state and registered-output logic. Illegal requests enter DONE with
    // out_valid still low; it rises one cycle later, fixing the reject latency at one.
    always_comb begin
        state_d     = state_q;
        cw_d        = cw_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        syndrome_d  = syndrome_q;
        status_d    = status_q;
        err_pos_d   = err_pos_q;

        case (state_q)
            S_IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    cw_d       = 32'(data_in) & cw_mask(work_mod[1:0]);
                    mode_d     = work_mod[1:0];
                    acc_d      = '0;
                    cnt_d      = '0;
                    if (mode_legal) begin
                        state_d = S_CALC;
                    end else begin
                        state_d    = S_DONE;
                        syndrome_d = '0;
                        status_d   = ST_ILLEGAL;
                        err_pos_d  = '0;
                    end
                end
            end
            S_CALC: begin
                in_ready_d = 1'b0;
                acc_d      = acc_nxt;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == last_cnt) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    syndrome_d  = MAX_PARITY_WIDTH'(acc_nxt);
                    status_d    = cls_status;
                    err_pos_d   = cls_pos;
                end
            end
            S_DONE: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cw_q        <= '0;
            mode_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            syndrome_q  <= '0;
            status_q    <= ST_NONE;
            err_pos_q   <= '0;
        end else begin
            state_q     <= state_d;
            cw_q        <= cw_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            syndrome_q  <= syndrome_d;
            status_q    <= status_d;
            err_pos_q   <= err_pos_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign syndrome  = syndrome_q;
    assign status    = status_q;
    assign err_pos   = err_pos_q;

endmodule

// File: tb/tb_dec_syndrome_seq.sv
// Bench for dec_syndrome_seq: two instances (CHUNK_WIDTH 8 and 1) driven from a
// vector table, a reference model for random codewords, and multi-cycle corner cases.
module tb_dec_syndrome_seq;

    localparam logic [31:0]  H0 = 32'hFFE4_D2B1;
    localparam logic [79:0]  H1 = 80'hFFFF_FE08_F1C4_CDA2_AB61;
    localparam logic [191:0] H2 = 192'hFFFF_FFFF_FFFE_0010_FF01_FC08_F0F1_E384_CCCD_9B42_AAAB_56C1;

    logic        clk;
    logic        rst;
    logic        in_valid_a  [2];
    logic        in_ready_a  [2];
    logic [31:0] data_a      [2];
    logic [31:0] mode_a      [2];
    logic        out_valid_a [2];
    logic        out_ready_a [2];
    logic [5:0]  syn_a       [2];
    logic [1:0]  st_a        [2];
    logic [4:0]  pos_a       [2];

    int total;
    int bad;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mode;
        logic [5:0]  syn;
        logic [1:0]  st;
        logic [4:0]  pos;
    } vec_t;

    typedef struct {
        logic [5:0] syn;
        logic [1:0] st;
        logic [4:0] pos;
        int         lat;
    } exp_t;

    exp_t sb_q[$];

    dec_syndrome_seq #(.CHUNK_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .data_in(data_a[0]), .work_mod(mode_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .syndrome(syn_a[0]), .status(st_a[0]), .err_pos(pos_a[0])
    );

    dec_syndrome_seq #(.CHUNK_WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .data_in(data_a[1]), .work_mod(mode_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .syndrome(syn_a[1]), .status(st_a[1]), .err_pos(pos_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Reference: straight bit-serial H x codeword over the whole mode width.
    task automatic model(input logic [31:0] d, input int m,
                         output logic [5:0] syn, output logic [1:0] st, output logic [4:0] pos);
        logic [191:0] hm;
        logic [31:0]  hr [6];
        logic [31:0]  mask;
        logic [5:0]   col;
        int           cw;
        int           p;
        bit           hit;
        syn = '0; st = 2'b11; pos = '0;
        if (m > 2) return;
        cw   = 8 << m;
        p    = 4 + m;
        hm   = (m == 0) ? 192'(H0) : (m == 1) ? 192'(H1) : H2;
        mask = (m == 2) ? 32'hFFFF_FFFF : ((32'h1 << cw) - 32'h1);
        for (int b = 0; b < 6; b++) begin
            hr[b] = (b < p) ? (32'(hm >> (b * cw)) & mask) : 32'h0;
            for (int j = 0; j < cw; j++) syn[b] = syn[b] ^ (hr[b][j] & d[j]);
        end
        hit = 1'b0;
        if (syn == 6'd0) begin
            st = 2'b00;
        end else begin
            st = 2'b10;
            if (syn[p-1]) begin
                for (int c = 0; c < cw; c++) begin
                    for (int b = 0; b < 6; b++) col[b] = hr[b][c];
                    if (!hit && col == syn) begin
                        hit = 1'b1; st = 2'b01; pos = 5'(c);
                    end
                end
            end
        end
    endtask

    // One transaction on DUT d; optional back-pressure hold of 'hold' cycles.
    task automatic do_txn(input int d, input logic [31:0] data, input logic [31:0] mode,
                          input logic [5:0] syn, input logic [1:0] st, input logic [4:0] pos,
                          input int hold, input string nm);
        exp_t e;
        int   cyc;
        bit   got;
        int   chunk;
        chunk = (d == 0) ? 8 : 1;
        @(negedge clk);
        out_ready_a[d] = 1'b1;
        in_valid_a[d]  = 1'b1;
        data_a[d]      = data;
        mode_a[d]      = mode;
        cyc = 0;
        while (!in_ready_a[d] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready_a[d]) begin
            check({nm, " accept_timeout"}, 0, 1);
            in_valid_a[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid_a[d] = 1'b0;
        e.syn = syn; e.st = st; e.pos = pos;
        e.lat = (mode < 3) ? ((8 << mode) / chunk) : 1;
        sb_q.push_back(e);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 80) begin
            if (out_valid_a[d]) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            check({nm, " out_valid_timeout"}, 0, 1);
            return;
        end
        check({nm, " latency"}, cyc, e.lat);
        check({nm, " syndrome"}, syn_a[d], e.syn);
        check({nm, " status"}, st_a[d], e.st);
        check({nm, " err_pos"}, pos_a[d], e.pos);
        if (hold > 0) begin
            out_ready_a[d] = 1'b0;
            in_valid_a[d]  = 1'b1;
            data_a[d]      = 32'h1;
            mode_a[d]      = 32'h0;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                check($sformatf("%s hold%0d out_valid", nm, k), out_valid_a[d], 1);
                check($sformatf("%s hold%0d in_ready", nm, k), in_ready_a[d], 0);
                check($sformatf("%s hold%0d syndrome", nm, k), syn_a[d], e.syn);
                check($sformatf("%s hold%0d status", nm, k), st_a[d], e.st);
            end
            in_valid_a[d]  = 1'b0;
            out_ready_a[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        check({nm, " out_valid_drop"}, out_valid_a[d], 0);
        check({nm, " in_ready_back"}, in_ready_a[d], 1);
    endtask

    vec_t vecs[13];

    initial begin
        logic [5:0]  ms;
        logic [1:0]  mst;
        logic [4:0]  mp;
        logic [31:0] rd;
        int          seen;

        total = 0;
        bad   = 0;
        vecs[0]  = '{32'h0000_0000, 0, 6'h00, 2'b00, 5'd0};
        vecs[1]  = '{32'h0000_0001, 0, 6'h09, 2'b01, 5'd0};
        vecs[2]  = '{32'h0000_0080, 0, 6'h0F, 2'b01, 5'd7};
        vecs[3]  = '{32'h0000_0081, 0, 6'h06, 2'b10, 5'd0};
        vecs[4]  = '{32'hFFFF_FF01, 0, 6'h09, 2'b01, 5'd0};
        vecs[5]  = '{32'h0000_0000, 2, 6'h00, 2'b00, 5'd0};
        vecs[6]  = '{32'h8000_0000, 2, 6'h3F, 2'b01, 5'd31};
        vecs[7]  = '{32'h0000_0001, 2, 6'h21, 2'b01, 5'd0};
        vecs[8]  = '{32'h0000_0003, 2, 6'h03, 2'b10, 5'd0};
        vecs[9]  = '{32'h0000_8000, 1, 6'h1F, 2'b01, 5'd15};
        vecs[10] = '{32'h0000_0001, 1, 6'h11, 2'b01, 5'd0};
        vecs[11] = '{32'hABCD_0001, 1, 6'h11, 2'b01, 5'd0};
        vecs[12] = '{32'h0000_0012, 5, 6'h00, 2'b11, 5'd0};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid_a[d] = 1'b0; out_ready_a[d] = 1'b1;
            data_a[d] = '0; mode_a[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset d%0d in_ready", d), in_ready_a[d], 1);
            check($sformatf("reset d%0d out_valid", d), out_valid_a[d], 0);
            check($sformatf("reset d%0d syndrome", d), syn_a[d], 0);
            check($sformatf("reset d%0d status", d), st_a[d], 0);
            check($sformatf("reset d%0d err_pos", d), pos_a[d], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            for (int d = 0; d < 2; d++) begin
                do_txn(d, vecs[i].data, vecs[i].mode, vecs[i].syn, vecs[i].st, vecs[i].pos,
                       0, $sformatf("v%0d.d%0d", i, d));
            end
        end

        for (int i = 0; i < 6; i++) begin
            rd = $urandom;
            if (i == 5) rd = 32'h0000_0600;
            model(rd, i % 3, ms, mst, mp);
            for (int d = 0; d < 2; d++) begin
                do_txn(d, rd, 32'(i % 3), ms, mst, mp, 0, $sformatf("rnd%0d.d%0d", i, d));
            end
        end

        do_txn(0, 32'h0000_005A, 32'd3, 6'h00, 2'b11, 5'd0, 5, "illegal_bp");
        do_txn(1, 32'h0000_0081, 32'd0, 6'h06, 2'b10, 5'd0, 3, "bp_chunk1");

        // Reset during the second CALC cycle of a mode 2 transaction.
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        data_a[0]     = 32'h8000_0000;
        mode_a[0]     = 32'd2;
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst in_ready", in_ready_a[0], 1);
        check("midrst out_valid", out_valid_a[0], 0);
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid_a[0]) seen++;
        end
        check("midrst no_out_valid", seen, 0);
        do_txn(0, 32'h0000_0001, 32'd0, 6'h09, 2'b01, 5'd0, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
